// File: rtl/segway_pkg.sv
// Shared Segway definitions: UART divider default, command bytes and UART receiver state type.
package segway_pkg;

  localparam int unsigned BAUD_DIV_DEFAULT = 2604;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

  typedef enum logic {IDLE, RECEIVE} uart_rx_state_t;

endpackage

// File: rtl/uart_rcv.sv
// 8N1 LSB-first UART receiver presenting each byte with a rdy/clr_rdy handshake.
// Define UART_RCV_FRM_ERR_EN to add the frm_err stop-bit check output.
module uart_rcv
  import segway_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter int unsigned CNT_W    = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
`ifdef UART_RCV_FRM_ERR_EN
  ,
  output logic       frm_err
`endif
);

  // The reload is one less than the divider so each bit spans exactly BAUD_DIV clocks.
  localparam logic [CNT_W-1:0] HalfBit = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] FullBit = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       StopIdx = 4'd9;

  uart_rx_state_t   state_q, state_d;
  logic             rx_meta_q, rx_s;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             start_det, shift_en, frame_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s      <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = RECEIVE;
      RECEIVE: if (shift_en && (bit_cnt_q == StopIdx)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_det = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      IDLE:    start_det = ~rx_s;
      RECEIVE: shift_en  = (baud_cnt_q == '0);
      default: ;
    endcase
    frame_done = shift_en && (bit_cnt_q == StopIdx);
  end

  always_comb begin
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    if (start_det) begin
      baud_cnt_d = HalfBit;
      bit_cnt_d  = '0;
    end else if (shift_en) begin
      baud_cnt_d = FullBit;
      bit_cnt_d  = bit_cnt_q + 4'd1;
      // Start and stop samples never enter the data word.
      if ((bit_cnt_q != '0) && (bit_cnt_q != StopIdx)) begin
        shift_d = {rx_s, shift_q[7:1]};
      end
    end else if (state_q == RECEIVE) begin
      baud_cnt_d = baud_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // A completed frame wins over clr_rdy; a new start bit supersedes an unread byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data <= '0;
      rdy     <= 1'b0;
    end else if (frame_done) begin
      rx_data <= shift_q;
      rdy     <= 1'b1;
    end else if (start_det || clr_rdy) begin
      rdy     <= 1'b0;
    end
  end

`ifdef UART_RCV_FRM_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frm_err <= 1'b0;
    end else if (frame_done) begin
      frm_err <= ~rx_s;
    end else if (start_det || clr_rdy) begin
      frm_err <= 1'b0;
    end
  end
`endif

endmodule
